// File: rtl/cam_capture_pkg.sv
// cam_capture_pkg: FSM encodings and counter sizing shared by the camera capture front-end.
package cam_capture_pkg;

  typedef enum logic [1:0] {WAIT_VS, VBLANK, HBLANK, LINE} cap_state_t;
  typedef enum logic {E_IDLE, E_BURST} emit_state_t;

  localparam int unsigned DEF_LINE_SIZE = 640;
  localparam int unsigned DEF_LINES     = 480;

  // Width of a counter that must hold the value n itself.
  function automatic int unsigned cnt_w(input int unsigned n);
    return (n < 2) ? 1 : $clog2(n + 1);
  endfunction

  // Width of an index into n entries.
  function automatic int unsigned idx_w(input int unsigned n);
    return (n < 2) ? 1 : $clog2(n);
  endfunction

  localparam int unsigned PIX_W  = cnt_w(DEF_LINE_SIZE);
  localparam int unsigned LINE_W = cnt_w(DEF_LINES);

endpackage

// File: rtl/cam_line_buf.sv
// cam_line_buf: ping-pong luma line store, one write and one read port, read latency 1.
module cam_line_buf #(
  parameter int unsigned pLineSize = 640,
  parameter int unsigned AW        = 10
) (
  input  logic          CLK,
  input  logic          RST,
  input  logic          we,
  input  logic [AW:0]   waddr,
  input  logic [7:0]    wdata,
  input  logic          re,
  input  logic [AW:0]   raddr,
  output logic [7:0]    rdata
);

  logic [7:0] mem [2][pLineSize];

  always_ff @(posedge CLK) begin
    if (we) mem[waddr[AW]][waddr[AW-1:0]] <= wdata;
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST)     rdata <= '0;
    else if (re) rdata <= mem[raddr[AW]][raddr[AW-1:0]];
  end

endmodule

// File: rtl/cam_capture.sv
// cam_capture: YUV422 camera bytes to gap-free grayscale line bursts for the 3x3 filter.
// Optional crop window (pX0/pY0/pLines) is enabled by defining CAM_CAPTURE_CROP_EN.
module cam_capture
  import cam_capture_pkg::*;
#(
  parameter int unsigned pLineSize  = DEF_LINE_SIZE,
  parameter int unsigned pLumaPhase = 0,
  parameter int unsigned pX0        = 0,
  parameter int unsigned pY0        = 0,
  parameter int unsigned pLines     = DEF_LINES
) (
  input  logic       CLK,
  input  logic       RST,
  input  logic       CAM_VSYNC,
  input  logic       CAM_HREF,
  input  logic [7:0] CAM_D,
  output logic       OLINE,
  output logic [7:0] ODATA,
  output logic       OVSYNC,
  output logic       ERR
);

  localparam int unsigned   AW       = idx_w(pLineSize);
  localparam int unsigned   PW       = cnt_w(pLineSize);
  localparam logic [PW-1:0] LINE_MAX = PW'(pLineSize);
  localparam logic          LUMA_PH  = 1'(pLumaPhase);

  logic          vs_r1, href_r1;
  logic [7:0]    d_r1;
  cap_state_t    cs, cs_n;
  emit_state_t   es, es_n;
  logic          phase, cap_bank;
  logic [PW-1:0] pix_cnt;
  logic          line_start, line_end, luma, discard, skip, in_window;
  logic          store, wr, ovf, handoff, accept, collide;
  logic [AW-1:0] widx, rd_idx;
  logic [PW-1:0] rd_cnt;
  logic          rd_bank, last, busy, ovsync_n;

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      vs_r1   <= 1'b0;
      href_r1 <= 1'b0;
      d_r1    <= '0;
    end else begin
      vs_r1   <= CAM_VSYNC;
      href_r1 <= CAM_HREF;
      d_r1    <= CAM_D;
    end
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) cs <= WAIT_VS;
    else     cs <= cs_n;
  end

  // The HBLANK->LINE cycle already holds byte 0 of the line, so it is consumed as phase 0.
  always_comb begin
    cs_n       = cs;
    line_start = 1'b0;
    line_end   = 1'b0;
    luma       = 1'b0;
    discard    = 1'b0;
    unique case (cs)
      WAIT_VS: if (vs_r1) cs_n = VBLANK;
      VBLANK:  if (!vs_r1) cs_n = HBLANK;
      HBLANK: begin
        if (vs_r1) cs_n = VBLANK;
        else if (href_r1) begin
          cs_n       = LINE;
          line_start = 1'b1;
          luma       = (LUMA_PH == 1'b0);
        end
      end
      LINE: begin
        if (!href_r1) begin
          cs_n     = HBLANK;
          line_end = 1'b1;
        end else if (vs_r1) begin
          cs_n    = VBLANK;
          discard = 1'b1;
        end else begin
          luma = (phase == LUMA_PH);
        end
      end
      default: cs_n = WAIT_VS;
    endcase
  end

  assign store   = luma & ~skip;
  assign wr      = store & (line_start | (pix_cnt != LINE_MAX));
  assign ovf     = store & ~line_start & (pix_cnt == LINE_MAX);
  assign widx    = line_start ? '0 : pix_cnt[AW-1:0];
  assign handoff = line_end & (pix_cnt != '0) & in_window;
  assign accept  = handoff & (es == E_IDLE);
  assign collide = handoff & (es == E_BURST);

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      phase    <= 1'b0;
      pix_cnt  <= '0;
      cap_bank <= 1'b0;
    end else begin
      if (line_start)     phase <= 1'b1;
      else if (cs == LINE) phase <= ~phase;
      if (line_start) pix_cnt <= store ? PW'(1) : '0;
      else if (wr)    pix_cnt <= pix_cnt + PW'(1);
      if (accept) cap_bank <= ~cap_bank;
    end
  end

`ifdef CAM_CAPTURE_CROP_EN
  localparam int unsigned   XW    = cnt_w(pX0);
  localparam int unsigned   LW    = cnt_w(pY0 + pLines);
  localparam logic [XW-1:0] X0    = XW'(pX0);
  localparam logic [LW-1:0] Y0    = LW'(pY0);
  localparam logic [LW-1:0] Y_END = LW'(pY0 + pLines);

  logic [XW-1:0] xs;
  logic [LW-1:0] line_cnt;

  assign skip      = line_start ? (X0 != '0) : (xs != '0);
  assign in_window = (line_cnt >= Y0) && (line_cnt < Y_END);

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      xs       <= '0;
      line_cnt <= '0;
    end else begin
      if (line_start)             xs <= (luma && (X0 != '0)) ? X0 - XW'(1) : X0;
      else if (luma && xs != '0)  xs <= xs - XW'(1);
      if (cs == VBLANK && !vs_r1) line_cnt <= '0;
      else if (line_end && line_cnt != Y_END) line_cnt <= line_cnt + LW'(1);
    end
  end
`else
  assign skip      = 1'b0;
  assign in_window = 1'b1;
`endif

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) es <= E_IDLE;
    else     es <= es_n;
  end

  always_comb begin
    es_n = es;
    last = 1'b0;
    unique case (es)
      E_IDLE: if (accept) es_n = E_BURST;
      E_BURST: begin
        last = ((PW'(rd_idx) + PW'(1)) == rd_cnt);
        if (last) es_n = E_IDLE;
      end
      default: es_n = E_IDLE;
    endcase
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      rd_bank <= 1'b0;
      rd_idx  <= '0;
      rd_cnt  <= '0;
    end else if (accept) begin
      rd_bank <= cap_bank;
      rd_idx  <= '0;
      rd_cnt  <= pix_cnt;
    end else if (es == E_BURST) begin
      rd_idx <= rd_idx + AW'(1);
    end
  end

  // A VSYNC rise is held off while a burst is running or about to start.
  assign busy     = (es == E_BURST) | handoff;
  assign ovsync_n = (vs_r1 & ~OVSYNC & busy) ? 1'b0 : vs_r1;

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      OLINE  <= 1'b0;
      OVSYNC <= 1'b1;
      ERR    <= 1'b0;
    end else begin
      OLINE  <= (es == E_BURST);
      OVSYNC <= ovsync_n;
      ERR    <= ovf | collide | discard | (ERR & ~(ovsync_n & ~OVSYNC));
    end
  end

  cam_line_buf #(
    .pLineSize(pLineSize),
    .AW       (AW)
  ) u_buf (
    .CLK  (CLK),
    .RST  (RST),
    .we   (wr),
    .waddr({cap_bank, widx}),
    .wdata(d_r1),
    .re   (es == E_BURST),
    .raddr({rd_bank, rd_idx}),
    .rdata(ODATA)
  );

endmodule

// File: tb/tb_cam_capture.sv
// tb_cam_capture: scoreboard bench for cam_capture (YUYV and UYVY instances, pLineSize=8).
module tb_cam_capture;

  localparam int LS = 8;
`ifdef CAM_CAPTURE_CROP_EN
  localparam int X0 = 2;
  localparam int Y0 = 1;
  localparam int NL = 2;
`else
  localparam int X0 = 0;
  localparam int Y0 = 0;
  localparam int NL = 1 << 20;
`endif

  typedef struct {
    logic [7:0] d;
    int         cyc;
  } exp_t;

  logic       clk = 1'b0;
  logic       rst;
  logic       vs_a, hr_a, vs_b, hr_b;
  logic [7:0] d_a, d_b;
  logic       oline_a, ovs_a, err_a, oline_b, ovs_b, err_b;
  logic [7:0] odata_a, odata_b;

  exp_t qa[$], qb[$];
  exp_t ea, eb;
  int   cyc = 0;
  int   n_tests = 0, n_fail = 0;
  int   line_no[2];
  bit   armed[2];

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  cam_capture #(.pLineSize(LS), .pLumaPhase(0), .pX0(2), .pY0(1), .pLines(2)) dut_a (
    .CLK(clk), .RST(rst), .CAM_VSYNC(vs_a), .CAM_HREF(hr_a), .CAM_D(d_a),
    .OLINE(oline_a), .ODATA(odata_a), .OVSYNC(ovs_a), .ERR(err_a));

  cam_capture #(.pLineSize(LS), .pLumaPhase(1), .pX0(2), .pY0(1), .pLines(2)) dut_b (
    .CLK(clk), .RST(rst), .CAM_VSYNC(vs_b), .CAM_HREF(hr_b), .CAM_D(d_b),
    .OLINE(oline_b), .ODATA(odata_b), .OVSYNC(ovs_b), .ERR(err_b));

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  always @(negedge clk) begin
    if (!rst) begin
      if (oline_a) begin
        if (qa.size() == 0) check("a_extra_pixel", {24'h0, odata_a}, 32'hffff_ffff);
        else begin
          ea = qa.pop_front();
          check("a_pix", {24'h0, odata_a}, {24'h0, ea.d});
          check("a_pix_cyc", cyc, ea.cyc);
        end
        if (ovs_a) check("a_vs_olap", 1, 0);
      end
      if (oline_b) begin
        if (qb.size() == 0) check("b_extra_pixel", {24'h0, odata_b}, 32'hffff_ffff);
        else begin
          eb = qb.pop_front();
          check("b_pix", {24'h0, odata_b}, {24'h0, eb.d});
          check("b_pix_cyc", cyc, eb.cyc);
        end
        if (ovs_b) check("b_vs_olap", 1, 0);
      end
    end
  end

  task automatic set_cam(input bit sel, input logic vs, input logic hr, input logic [7:0] d);
    if (sel) begin vs_b = vs; hr_b = hr; d_b = d; end
    else     begin vs_a = vs; hr_a = hr; d_a = d; end
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
  endtask

  task automatic start_frame(input bit sel);
    @(posedge clk); #1;
    set_cam(sel, 1'b1, 1'b0, 8'h00);
    idle(4); #1;
    set_cam(sel, 1'b0, 1'b0, 8'h00);
    idle(4);
    line_no[sel] = 0;
    armed[sel]   = 1'b1;
  endtask

  // Drives one line of n luma (chroma 0x80) and queues the expected burst.
  task automatic send_line(input bit sel, input int n, input logic [7:0] base,
                           output int kend, output int npix);
    logic [7:0] b;
    exp_t e;
    for (int i = 0; i < 2 * n; i++) begin
      @(posedge clk); #1;
      if ((i % 2) == (sel ? 1 : 0)) b = base + 8'(i / 2);
      else b = 8'h80;
      set_cam(sel, 1'b0, 1'b1, b);
    end
    @(posedge clk); #1;
    set_cam(sel, 1'b0, 1'b0, 8'h00);
    kend = cyc;
    npix = 0;
    if (armed[sel] && line_no[sel] >= Y0 && line_no[sel] < Y0 + NL && n > X0) begin
      npix = (n - X0 > LS) ? LS : n - X0;
      for (int j = 0; j < npix; j++) begin
        e.d   = base + 8'(X0 + j);
        e.cyc = kend + 3 + j;
        if (sel) qb.push_back(e);
        else     qa.push_back(e);
      end
    end
    if (armed[sel]) line_no[sel]++;
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: time limit reached at cycle %0d", cyc);
    $fatal(1);
  end

  initial begin
    int kend, npix, got;
    rst = 1'b1;
    set_cam(1'b0, 1'b0, 1'b0, 8'h00);
    set_cam(1'b1, 1'b0, 1'b0, 8'h00);
    armed[0] = 1'b0;
    armed[1] = 1'b0;
    idle(3);
    @(negedge clk);
    check("rst_oline", oline_a, 0);
    check("rst_odata", odata_a, 0);
    check("rst_ovsync", ovs_a, 1);
    check("rst_err", err_a, 0);
    @(posedge clk); #1;
    rst = 1'b0;
    idle(3);

    // Partial frame after reset is discarded, then a 4-line YUYV frame.
    send_line(1'b0, 8, 8'h60, kend, npix);
    idle(12);
    start_frame(1'b0);
    for (int l = 0; l < 4; l++) begin
      send_line(1'b0, 8, 8'h10, kend, npix);
      idle(6);
    end
    idle(16);
    check("a_frame_drain", qa.size(), 0);
    check("a_frame_err", err_a, 0);

    // UYVY stream on the pLumaPhase=1 instance.
    start_frame(1'b1);
    for (int l = 0; l < 3; l++) begin
      send_line(1'b1, 8, 8'h20, kend, npix);
      idle(6);
    end
    idle(16);
    check("b_frame_drain", qb.size(), 0);
    check("b_err", err_b, 0);

    // Overflow: 12 luma into an 8-pixel line.
    start_frame(1'b0);
    send_line(1'b0, 4, 8'h40, kend, npix);
    idle(12);
    send_line(1'b0, 12, 8'h30, kend, npix);
    idle(20);
    check("ovf_drain", qa.size(), 0);
    check("ovf_err_set", err_a, 1);
    @(posedge clk); #1;
    set_cam(1'b0, 1'b1, 1'b0, 8'h00);
    @(negedge clk);
    @(negedge clk);
    check("ovf_err_hold", err_a, 1);
    check("ovs_lag1", ovs_a, 0);
    @(negedge clk);
    check("ovf_err_clr", err_a, 0);
    check("ovs_lag2", ovs_a, 1);
    idle(4);

    // VSYNC rising one cycle after HREF falls: OVSYNC rise waits for the burst.
    start_frame(1'b0);
    send_line(1'b0, 8, 8'h50, kend, npix);
    idle(12);
    send_line(1'b0, 8, 8'h70, kend, npix);
    @(posedge clk); #1;
    set_cam(1'b0, 1'b1, 1'b0, 8'h00);
    got = -1;
    for (int i = 0; i < 60; i++) begin
      @(negedge clk);
      if (ovs_a) begin
        got = cyc;
        break;
      end
    end
    check("ovs_defer_cyc", got, kend + 3 + npix);
    idle(6);
    check("defer_drain", qa.size(), 0);

    // Reset in the middle of a burst.
    start_frame(1'b0);
    send_line(1'b0, 8, 8'h90, kend, npix);
    idle(12);
    send_line(1'b0, 8, 8'ha0, kend, npix);
    repeat (5) @(posedge clk);
    #1;
    check("pre_rst_oline", oline_a, 1);
    rst = 1'b1;
    #1;
    check("mid_rst_oline", oline_a, 0);
    check("mid_rst_ovsync", ovs_a, 1);
    check("mid_rst_odata", odata_a, 0);
    qa.delete();
    qb.delete();
    armed[0] = 1'b0;
    armed[1] = 1'b0;
    idle(2); #1;
    rst = 1'b0;
    send_line(1'b0, 8, 8'hb0, kend, npix);
    idle(16);
    start_frame(1'b0);
    for (int l = 0; l < 2; l++) begin
      send_line(1'b0, 8, 8'hc0, kend, npix);
      idle(6);
    end
    idle(16);
    check("post_rst_drain", qa.size(), 0);
    check("post_rst_err", err_a, 0);
    check("final_b_drain", qb.size(), 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
